// File: rtl/fifo_reader_serializer.sv
// Purpose: drains width-bit words from a FIFO pop port and serializes each word into
//          ratio = width/out_width narrow beats, least-significant chunk first.
// Latency: FIFO non-empty in IDLE at cycle N pops at N and presents beat 0 at N+1.
// Backpressure: a presented beat, with its data and last flag, holds until out_ready. The
//          next word is popped only on acceptance of the last beat, so full-rate
//          streaming has no bubble.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   fifo_empty      FIFO empty flag
//   fifo_read_data  FIFO head word, valid while fifo_empty = 0
//   fifo_pop        combinational pop strobe to the FIFO
//   out_valid/out_ready/out_data/out_last   narrow beat stream, last beat of a word flagged
//   busy            high while a word is being sent
//   word_count      16-bit wrapping count of pops (only with FIFO_READER_SERIALIZER_STATS_EN)
//
// Optional feature macro: FIFO_READER_SERIALIZER_STATS_EN adds the word_count port and counter.
// width must be a multiple of out_width, with width/out_width >= 2.
module fifo_reader_serializer #(
    parameter int width     = 8,
    parameter int out_width = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_read_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef FIFO_READER_SERIALIZER_STATS_EN
    ,
    output logic [15:0]          word_count
`endif
);

    localparam int ratio = width / out_width;
    localparam int cnt_w = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(ratio - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [width-1:0] sreg;
    logic [cnt_w-1:0] beat_cnt;
    logic             accept;

    // All stream outputs come straight from registers.
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_data  = sreg[out_width-1:0];
    assign out_last  = (state == SEND) && (beat_cnt == last_cnt);
    assign accept    = out_valid & out_ready;

    // Pop when idle, or on the accepted last beat so the next word follows with no
    // bubble. Gated by rst so the FIFO is never drained while we are held in reset.
    assign fifo_pop = !rst && !fifo_empty && ((state == IDLE) || (accept && out_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        sreg     <= fifo_read_data;
                        beat_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (out_last) begin
                            if (fifo_pop) begin
                                sreg     <= fifo_read_data;
                                beat_cnt <= '0;
                            end else begin
                                // sreg/beat_cnt left stale; out_valid is low in IDLE.
                                state <= IDLE;
                            end
                        end else begin
                            sreg     <= sreg >> out_width;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_READER_SERIALIZER_STATS_EN
    // Counts every pop; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (fifo_pop) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader_serializer.sv
// Purpose: self-checking bench for fifo_reader_serializer at width=8, out_width=2.
// Latency: a FIFO model feeds the DUT; popped words push expected beats to a scoreboard.
// Backpressure: out_ready is driven per cycle by each scenario task.
module tb_fifo_reader_serializer;

    localparam int W  = 8;
    localparam int OW = 2;
    localparam int R  = W / OW;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_read_data;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef FIFO_READER_SERIALIZER_STATS_EN
    logic [15:0]   word_count;
`endif

    fifo_reader_serializer #(.width(W), .out_width(OW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_pop       (fifo_pop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy)
`ifdef FIFO_READER_SERIALIZER_STATS_EN
        ,
        .word_count     (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]    fq[$];      // FIFO contents model
    logic [OW:0]     exp_q[$];   // expected {last, data} beats of popped words
    logic [OW-1:0]   acc[$];     // data of beats the DUT actually delivered
    int              checks = 0;
    int              errors = 0;
    int              pops   = 0;

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic rdy);
        logic       exp_pop;
        logic       exp_vld;
        logic [W-1:0] w;
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_read_data = fifo_empty ? W'($urandom) : fq[0];
        #1;
        exp_vld = (exp_q.size() != 0);
        exp_pop = !fifo_empty && ((exp_q.size() == 0) || (exp_q.size() == 1 && rdy));
        checks++;
        if (out_valid !== exp_vld || busy !== exp_vld) begin
            errors++;
            $display("FAIL valid: out_valid=%b busy=%b required %b", out_valid, busy, exp_vld);
        end
        checks++;
        if (fifo_pop !== exp_pop) begin
            errors++;
            $display("FAIL pop: fifo_pop=%b required %b", fifo_pop, exp_pop);
        end
        if (exp_vld) begin
            checks++;
            if ({out_last, out_data} !== exp_q[0]) begin
                errors++;
                $display("FAIL beat: last/data=%b/%0d required %b/%0d",
                         out_last, out_data, exp_q[0][OW], exp_q[0][OW-1:0]);
            end
            if (rdy) begin
                acc.push_back(out_data);
                void'(exp_q.pop_front());
            end
        end
        if (exp_pop) begin
            w = fq.pop_front();
            pops++;
            for (int i = 0; i < R; i++) exp_q.push_back({(i == R - 1), w[OW*i +: OW]});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < 60) begin
            cycle(1'b1);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: cycles=%0d limit 60", n);
        end
        cycle(1'b1);
    endtask

    task automatic test_reset();
        logic [OW-1:0] want[4] = '{2'd2, 2'd2, 2'd1, 2'd1};
        fq.push_back(8'h5A);
        repeat (2) begin
            out_ready = 1'b1;
            fifo_empty = 1'b0;
            fifo_read_data = 8'h5A;
            #1;
            checks++;
            if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
                out_last !== 1'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs: pop=%b vld=%b busy=%b last=%b data=%0d required all 0",
                         fifo_pop, out_valid, busy, out_last, out_data);
            end
`ifdef FIFO_READER_SERIALIZER_STATS_EN
            checks++;
            if (word_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_word_count: %0d required 0", word_count);
            end
`endif
            @(negedge clk);
        end
        rst = 1'b0;
        pops = 0;
        acc.delete();
        cycle(1'b1);
        checks++;
        if (pops != 1) begin
            errors++;
            $display("FAIL reset_first_pop: pops=%0d required 1", pops);
        end
        drain();
        checks++;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL reset_beats: count=%0d required 4", acc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc[i] !== want[i]) begin
                    errors++;
                    $display("FAIL reset_beat%0d: %0d required %0d", i, acc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_single_word();
        logic [OW-1:0] want[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        acc.delete();
        pops = 0;
        fq.push_back(8'hB4);
        repeat (6) cycle(1'b1);
        checks++;
        if (pops != 1 || acc.size() != 4) begin
            errors++;
            $display("FAIL single_counts: pops=%0d beats=%0d required 1 and 4", pops, acc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc[i] !== want[i]) begin
                    errors++;
                    $display("FAIL single_beat%0d: %0d required %0d", i, acc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] want[8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
        acc.delete();
        pops = 0;
        fq.push_back(8'hB4);
        fq.push_back(8'h1E);
        repeat (10) cycle(1'b1);
        checks++;
        if (pops != 2 || acc.size() != 8) begin
            errors++;
            $display("FAIL b2b_counts: pops=%0d beats=%0d required 2 and 8", pops, acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc[i] !== want[i]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: %0d required %0d", i, acc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] want[8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
        acc.delete();
        pops = 0;
        fq.push_back(8'hB4);
        fq.push_back(8'h1E);
        repeat (3) cycle(1'b1);
        repeat (3) begin
            cycle(1'b0);
            checks++;
            if (out_data !== 2'd3 || out_valid !== 1'b1 || pops != 1) begin
                errors++;
                $display("FAIL stall_hold: data=%0d vld=%b pops=%0d required 3 1 1",
                         out_data, out_valid, pops);
            end
        end
        drain();
        checks++;
        if (pops != 2 || acc.size() != 8) begin
            errors++;
            $display("FAIL bp_counts: pops=%0d beats=%0d required 2 and 8", pops, acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc[i] !== want[i]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: %0d required %0d", i, acc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_empty_at_last();
        logic [OW-1:0] want[8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        acc.delete();
        pops = 0;
        fq.push_back(8'hB4);
        repeat (5) cycle(1'b1);
        repeat (5) cycle(1'b1);
        fq.push_back(8'hFF);
        cycle(1'b1);
        checks++;
        if (pops != 2) begin
            errors++;
            $display("FAIL late_word_pop: pops=%0d required 2", pops);
        end
        repeat (5) cycle(1'b1);
        checks++;
        if (acc.size() != 8) begin
            errors++;
            $display("FAIL empty_last_counts: beats=%0d required 8", acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc[i] !== want[i]) begin
                    errors++;
                    $display("FAIL empty_last_beat%0d: %0d required %0d", i, acc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        acc.delete();
        pops = 0;
        fq.push_back(8'hB4);
        fq.push_back(8'h1E);
        repeat (3) cycle(1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: vld=%b busy=%b last=%b data=%0d pop=%b required all 0",
                     out_valid, busy, out_last, out_data, fifo_pop);
        end
`ifdef FIFO_READER_SERIALIZER_STATS_EN
        checks++;
        if (word_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_word_count: %0d required 0", word_count);
        end
`endif
        @(negedge clk);
        exp_q.delete();
        fq.delete();
        rst = 1'b0;
        acc.delete();
        repeat (4) cycle(1'b1);
        checks++;
        if (acc.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_replay: beats=%0d required 0", acc.size());
        end
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        drain();
        checks++;
        if (acc.size() != 12) begin
            errors++;
            $display("FAIL post_reset_beats: beats=%0d required 12", acc.size());
        end
`ifdef FIFO_READER_SERIALIZER_STATS_EN
        checks++;
        if (word_count !== 16'd3) begin
            errors++;
            $display("FAIL post_reset_word_count: %0d required 3", word_count);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_read_data = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_empty_at_last();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
